// File: rtl/timer.sv
// timer: programmable interval timer used as a CP0 interrupt source.
// Word-addressed register window:
//   Addr 0 CTRL   {28'b0, IM, Mode[1:0], Enable}
//   Addr 1 PRESET 32-bit reload value
//   Addr 2 COUNT  32-bit down-counter (read-only)
//   Addr 3 unused (reads 0)
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   Addr  word select [3:2]
//   We    write strobe
//   Din   write data
//   Dout  combinational read of the selected register
//   IRQ   interrupt: level (pending & IM) in one-shot modes,
//         one-cycle pulse per period in auto-reload mode
module timer (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:2]  Addr,
  input  logic        We,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic        im;
  logic [1:0]  mode;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;

  logic reload;
  logic int_set;

  // Only mode 1 auto-reloads; modes 0, 2 and 3 are one-shot.
  assign reload  = (mode == 2'd1);
  // One-shot expiry this cycle: pending is being set on this edge.
  assign int_set = (state == INT) && !reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      en      <= 1'b0;
      im      <= 1'b0;
      mode    <= 2'd0;
      preset  <= 32'd0;
      count   <= 32'd0;
      pending <= 1'b0;
    end else begin
      // CPU writes to CTRL/PRESET clear pending, unless an expiry sets
      // it on the same edge: set wins so no interrupt is lost.
      if (We && (Addr == 2'd0 || Addr == 2'd1) && !int_set)
        pending <= 1'b0;
      if (We && Addr == 2'd1)
        preset <= Din;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count <= 32'd1) begin
            // PRESET 0 and 1 both spend exactly one cycle here
            count <= 32'd0;
            state <= INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        INT: begin
          if (reload) begin
            state <= LOAD;
          end else begin
            pending <= 1'b1;
            en      <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Placed after the FSM so a CPU CTRL write overrides the
      // expiry's Enable clear on the same edge.
      if (We && Addr == 2'd0) begin
        en   <= Din[0];
        mode <= Din[2:1];
        im   <= Din[3];
      end
    end
  end

  assign IRQ = im & (reload ? (state == INT) : pending);

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'd0:    Dout = {28'd0, im, mode, en};
      2'd1:    Dout = preset;
      2'd2:    Dout = count;
      default: Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer.sv
// tb_timer: self-checking bench for timer. Register vector table,
// hand-written corner sequences, and randomized programs checked
// against an arithmetic timing model.
module tb_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int nchk = 0;
  int nerr = 0;

  timer dut (
    .clk  (clk),
    .rst  (rst),
    .Addr (addr),
    .We   (we),
    .Din  (din),
    .Dout (dout),
    .IRQ  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] din;
    logic [1:0]  raddr;
    logic [31:0] exp_dout;
    logic        exp_irq;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic do_reset();
    we  = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Timing model, k = edges after the CTRL write that sets Enable,
  // starting from a freshly reset timer.
  function automatic int len_of(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  function automatic logic m_irq(input int k, input int p, input int md, input logic im);
    int l = len_of(p);
    if (md == 1) return im && (k >= 1) && (((k - 1) % (l + 2)) == l + 1);
    return im && (k >= l + 3);
  endfunction

  function automatic int m_cnt(input int k, input int p, input int md);
    int l = len_of(p);
    int ph;
    if (k < 1) return 0;
    if (md == 1) begin
      ph = (k - 1) % (l + 2);
      if (ph == 0 || ph == l + 1) return 0;
      return (p > ph - 1) ? p - (ph - 1) : 0;
    end
    if (k < 2) return 0;
    return (p > k - 2) ? p - (k - 2) : 0;
  endfunction

  function automatic logic m_en(input int k, input int p, input int md);
    if (md == 1) return 1'b1;
    return k < len_of(p) + 3;
  endfunction

  vec_t vecs[10];
  logic [31:0] v;

  initial begin
    // Register window vectors, Enable always 0 so the FSM stays idle.
    vecs[0] = '{1'b0, 2'd0, 32'h0,        2'd0, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 2'd0, 32'h0,        2'd1, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 2'd0, 32'h0,        2'd2, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 32'h6,        2'd0, 32'h6,        1'b0};
    vecs[5] = '{1'b1, 2'd0, 32'hFFFFFFF0, 2'd0, 32'h0,        1'b0};
    vecs[6] = '{1'b1, 2'd2, 32'h12345678, 2'd2, 32'h0,        1'b0};
    vecs[7] = '{1'b1, 2'd3, 32'h55,       2'd3, 32'h0,        1'b0};
    vecs[8] = '{1'b1, 2'd1, 32'h0,        2'd1, 32'h0,        1'b0};
    vecs[9] = '{1'b1, 2'd0, 32'h8,        2'd0, 32'h8,        1'b0};

    #3;
    rst = 1'b1;
    #1;
    chk("reset irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].din);
      else tick();
      rd(vecs[i].raddr, v);
      chk($sformatf("vec%0d dout", i), v, vecs[i].exp_dout);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
    end

    // Mode 0 one-shot, PRESET 3
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    for (int k = 2; k <= 5; k++) begin
      tick();
      rd(2'd2, v);
      chk($sformatf("m0 count k%0d", k), v, 32'(5 - k));
      chk($sformatf("m0 irq k%0d", k), {31'd0, irq}, 32'd0);
    end
    tick();
    chk("m0 irq rise", {31'd0, irq}, 32'd1);
    rd(2'd0, v);
    chk("m0 ctrl en clr", v, 32'h8);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("m0 irq hold %0d", i), {31'd0, irq}, 32'd1);
    end
    wr(2'd0, 32'h0);
    chk("m0 irq clr", {31'd0, irq}, 32'd0);

    // Mode 1 auto-reload, PRESET 5: period 7
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 35; k++) begin
      tick();
      chk($sformatf("m1 irq k%0d", k), {31'd0, irq}, {31'd0, ((k - 1) % 7) == 6});
      if (((k - 1) % 7) == 1) begin
        rd(2'd2, v);
        chk($sformatf("m1 reload k%0d", k), v, 32'd5);
      end
    end

    // PRESET 0 with IM
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("p0 irq k%0d", k), {31'd0, irq}, {31'd0, k == 4});
    end
    // PRESET 0 masked
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("mask irq k%0d", k), {31'd0, irq}, 32'd0);
      if (k == 3 || k == 4) begin
        rd(2'd0, v);
        chk($sformatf("mask ctrl k%0d", k), v, (k == 3) ? 32'h1 : 32'h0);
      end
    end

    // Disable mid-count: the write edge still decrements 100 -> 99,
    // then CNT sees Enable=0 and holds.
    do_reset();
    wr(2'd1, 32'd150);
    wr(2'd0, 32'h1);
    repeat (52) tick();
    rd(2'd2, v);
    chk("dis count 100", v, 32'd100);
    wr(2'd0, 32'h0);
    repeat (10) tick();
    rd(2'd2, v);
    chk("dis frozen", v, 32'd99);
    repeat (10) tick();
    rd(2'd2, v);
    chk("dis still frozen", v, 32'd99);

    // Reprogram PRESET during CNT in mode 1
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hB);
    repeat (3) tick();
    rd(2'd2, v);
    chk("rep count k3", v, 32'd3);
    wr(2'd1, 32'd2);
    rd(2'd2, v);
    chk("rep count k4", v, 32'd2);
    for (int k = 5; k <= 12; k++) begin
      tick();
      chk($sformatf("rep irq k%0d", k), {31'd0, irq}, {31'd0, (k == 6) || (k == 10)});
      if (k == 8) begin
        rd(2'd2, v);
        chk("rep new preset", v, 32'd2);
      end
    end

    // Async reset during INT
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    repeat (5) tick();
    chk("ar int irq", {31'd0, irq}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar int irq drop", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk($sformatf("ar int reg%0d", a), v, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("ar post irq %0d", i), {31'd0, irq}, 32'd0);
    end
    // Async reset during CNT
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    repeat (3) tick();
    rd(2'd2, v);
    chk("ar cnt count", v, 32'd2);
    #1;
    rst = 1'b0;
    #1;
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      chk($sformatf("ar cnt reg%0d", a), v, 32'd0);
    end
    chk("ar cnt irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    repeat (10) tick();
    chk("ar cnt post irq", {31'd0, irq}, 32'd0);

    // Collision: CTRL write on the edge the one-shot INT fires
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    wr(2'd0, 32'h1);
    rd(2'd0, v);
    chk("col ctrl", v, 32'h1);
    chk("col irq masked", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h8);
    chk("col cleared irq", {31'd0, irq}, 32'd0);
    repeat (5) tick();
    chk("col cleared later", {31'd0, irq}, 32'd0);
    // Same collision with IM kept: pending set must survive the write
    do_reset();
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    wr(2'd0, 32'h8);
    rd(2'd0, v);
    chk("col2 ctrl", v, 32'h8);
    chk("col2 irq", {31'd0, irq}, 32'd1);
    tick();
    chk("col2 irq hold", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h0);
    chk("col2 irq clr", {31'd0, irq}, 32'd0);

    // Randomized programs against the timing model
    for (int t = 0; t < 30; t++) begin
      int p;
      int md;
      logic im;
      p  = int'($urandom_range(0, 12));
      md = int'($urandom_range(0, 3));
      im = 1'($urandom_range(0, 1));
      do_reset();
      wr(2'd1, 32'(p));
      wr(2'd0, {28'd0, im, 2'(md), 1'b1});
      for (int k = 1; k <= 3 * (len_of(p) + 2) + 4; k++) begin
        tick();
        chk($sformatf("rnd%0d p%0d m%0d k%0d irq", t, p, md, k), {31'd0, irq},
            {31'd0, m_irq(k, p, md, im)});
        rd(2'd0, v);
        chk($sformatf("rnd%0d k%0d ctrl", t, k), v,
            {28'd0, im, 2'(md), m_en(k, p, md)});
        rd(2'd2, v);
        chk($sformatf("rnd%0d k%0d count", t, k), v, 32'(m_cnt(k, p, md)));
      end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
